// File: rtl/btn_event.sv
// ---------------------------------------------------------------------------
// btn_event
//
// Turns a debounced, clock-synchronous button level into one-cycle event
// pulses: press, release, long-press and auto-repeat. It also provides a
// "held" level and a running count of presses.
//
// Parameters
//   LONG_CYCLES   - hold time in clk cycles from press_pulse to long_pulse
//   REPEAT_CYCLES - period in clk cycles of repeat_pulse after long_pulse
//
// Ports
//   clk           - single clock, all logic on its rising edge
//   reset         - synchronous, active-high reset
//   btn_in        - debounced button level (1 = pressed)
//   press_pulse   - one-cycle pulse on each press
//   release_pulse - one-cycle pulse on each release
//   long_pulse    - one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  - one-cycle auto-repeat pulse while held past long press
//   held          - level, 1 while the FSM is not IDLE
//   press_count   - number of presses since reset, modulo 256
//
// Every output comes straight from a flop. Each pulse appears in the cycle
// after the edge that sampled the btn_in value causing it.
// ---------------------------------------------------------------------------
module btn_event #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Terminal counter values. The counter restarts from 0 on every
    // state change, so it never exceeds the larger of these two values.
    localparam logic [25:0] LONG_LAST   = 26'(LONG_CYCLES - 1);
    localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic        press_pulse_q, press_pulse_d;
    logic        release_pulse_q, release_pulse_d;
    logic        long_pulse_q, long_pulse_d;
    logic        repeat_pulse_q, repeat_pulse_d;
    logic        held_q, held_d;
    logic [7:0]  press_count_q, press_count_d;

    // State register. Reset overrides btn_in. Reset does not generate a
    // release_pulse, because all pulse flops clear here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            repeat_pulse_q  <= 1'b0;
            held_q          <= 1'b0;
            press_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            repeat_pulse_q  <= repeat_pulse_d;
            held_q          <= held_d;
            press_count_q   <= press_count_d;
        end
    end

    // Next-state and counter logic. A low sample is tested first, so a
    // release on the counter's terminal cycle aborts the long or repeat
    // event rather than firing it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (btn_in) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!btn_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            HOLD: begin
                if (!btn_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic. Each branch raises at most one pulse, so the four
    // pulse outputs are mutually exclusive.
    always_comb begin
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        repeat_pulse_d  = 1'b0;
        press_count_d   = press_count_q;
        case (state_q)
            IDLE: begin
                if (btn_in) begin
                    press_pulse_d = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                end
            end
            PRESS: begin
                if (!btn_in) begin
                    release_pulse_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    long_pulse_d = 1'b1;
                end
            end
            HOLD: begin
                if (!btn_in) begin
                    release_pulse_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_pulse_d = 1'b1;
                end
            end
            default: begin
                press_pulse_d = 1'b0;
            end
        endcase
        // held is registered alongside the state, so it follows state_q.
        held_d = (state_d != IDLE);
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign repeat_pulse  = repeat_pulse_q;
    assign held          = held_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_btn_event.sv
// ---------------------------------------------------------------------------
// tb_btn_event
//
// Scoreboard bench for btn_event with LONG_CYCLES=8 and REPEAT_CYCLES=4.
// The driver computes the expected outputs from a press/hold-length model
// and queues them. A monitor checks them against the DUT after every edge.
// ---------------------------------------------------------------------------
module tb_btn_event;

    localparam int LONG = 8;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    typedef struct packed {
        logic       press;
        logic       rel;
        logic       lng;
        logic       rpt;
        logic       held;
        logic [7:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: whether the button is down, how many high
    // samples followed the press sample, and the press total.
    bit         m_pressed = 1'b0;
    int         m_hold    = 0;
    logic [7:0] m_count   = 8'd0;

    btn_event #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the
    // next rising edge.
    task automatic applyStimulus(input logic b, input logic r);
        exp_t e;
        @(negedge clk);
        btn_in = b;
        reset  = r;
        e      = '0;
        if (r) begin
            m_pressed = 1'b0;
            m_hold    = 0;
            m_count   = 8'd0;
        end else if (!m_pressed) begin
            if (b) begin
                m_pressed = 1'b1;
                m_hold    = 0;
                m_count   = m_count + 8'd1;
                e.press   = 1'b1;
            end
        end else if (!b) begin
            m_pressed = 1'b0;
            e.rel     = 1'b1;
        end else begin
            m_hold = m_hold + 1;
            if (m_hold == LONG)
                e.lng = 1'b1;
            else if (m_hold > LONG && ((m_hold - LONG) % REP) == 0)
                e.rpt = 1'b1;
        end
        e.held  = m_pressed;
        e.count = m_count;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count} !== e) begin
            errors++;
            $display("[TB] FAIL outputs t=%0t actual p=%b r=%b l=%b rp=%b h=%b cnt=%0d required p=%b r=%b l=%b rp=%b h=%b cnt=%0d",
                     $time, press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count,
                     e.press, e.rel, e.lng, e.rpt, e.held, e.count);
        end
        checks++;
        if ($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) > 1) begin
            errors++;
            $display("[TB] FAIL onehot t=%0t actual pulses=%b required at most one high",
                     $time, {press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
    endtask

    // Monitor: one expected record is consumed per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic holdHigh(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
    endtask

    task automatic holdLow(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;

        // Reset state, with btn_in high so that reset must win.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        holdLow(3);

        // Short press, then a long hold into the repeat phase.
        holdHigh(5);
        holdLow(4);
        holdHigh(20);
        holdLow(3);

        // Release on the cycle the long counter reaches its terminal value.
        holdHigh(8);
        holdLow(3);

        // Back-to-back 1,0,1 after a fresh reset.
        applyStimulus(1'b0, 1'b1);
        holdLow(1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        holdLow(2);

        // Reset during the repeat phase, then a press on the first edge.
        applyStimulus(1'b0, 1'b1);
        holdLow(2);
        holdHigh(14);
        applyStimulus(1'b1, 1'b1);
        holdHigh(3);
        holdLow(2);

        // Counter wrap: 257 presses from reset.
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
        end
        holdLow(2);

        // Random runs of high/low levels with an occasional reset.
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 25) == 0)
                applyStimulus(1'($urandom_range(0, 1)), 1'b1);
            if (i % 2 == 0)
                holdHigh(int'($urandom_range(1, 22)));
            else
                holdLow(int'($urandom_range(1, 4)));
        end
        holdLow(3);

        // Let the monitor drain the final record.
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual pending=%0d required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
